// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TO_CYC = 15;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mux_2to1.sv
// Generic two-input multiplexer; sel=1 selects in1.
module mux_2to1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] dout
);

    assign dout = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one shared memory port, one transaction in flight with timeout.
// Optional build macro ARB_DATA_PRIO_EN: requester 1 always wins contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_we,
    output logic              r0_rvalid,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_we,
    output logic              r1_rvalid,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TO_CYC);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    logic              winner;
    logic              any_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              timeout;
    logic              done_ok;
    logic              done_err;
    logic              done_any;

    assign any_valid = r0_valid | r1_valid;

    always_comb begin
        winner = 1'b0;
`ifdef ARB_DATA_PRIO_EN
        winner = r1_valid;
`else
        if (r0_valid && r1_valid) begin
            winner = ~last_q;
        end else begin
            winner = r1_valid;
        end
`endif
    end

    mux_2to1 #(.WIDTH(ADDR_W)) u_mux_addr (
        .in0  (r0_addr),
        .in1  (r1_addr),
        .sel  (winner),
        .dout (sel_addr)
    );

    mux_2to1 #(.WIDTH(DATA_W)) u_mux_wdata (
        .in0  (r0_wdata),
        .in1  (r1_wdata),
        .sel  (winner),
        .dout (sel_wdata)
    );

    mux_2to1 #(.WIDTH(1)) u_mux_we (
        .in0  (r0_we),
        .in1  (r1_we),
        .sel  (winner),
        .dout (sel_we)
    );

    // A real response in the timeout cycle is delivered rather than discarded.
    assign timeout  = (state_q != IDLE) && (cnt_q == TO_LIM);
    assign done_ok  = (state_q == RESP) && mem_rvalid;
    assign done_err = timeout && !done_ok;
    assign done_any = done_ok | done_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    last_d  = winner;
                    owner_d = winner;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_err) begin
                    state_d = IDLE;
                end else if (mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // ready is combinational from valid, so it is gated by rst_n to stay low during reset.
    assign r0_ready  = rst_n && (state_q == IDLE) && any_valid && !winner;
    assign r1_ready  = rst_n && (state_q == IDLE) && any_valid && winner;

    assign r0_rvalid = done_any && !owner_q;
    assign r1_rvalid = done_any && owner_q;
    assign r0_err    = done_err && !owner_q;
    assign r1_err    = done_err && owner_q;
    assign r0_rdata  = (done_ok && !owner_q) ? mem_rdata : '0;
    assign r1_rdata  = (done_ok && owner_q) ? mem_rdata : '0;

    assign mem_req   = (state_q == REQ) && !timeout;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic          r0_ready, r1_ready;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_we = 1'b0, r1_we = 1'b0;
    logic          r0_rvalid, r1_rvalid, r0_err, r1_err;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_req;
    logic          mem_gnt = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_we(r0_we), .r0_rvalid(r0_rvalid), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_we(r1_we), .r1_rvalid(r1_rvalid), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int vectors = 0;
    int miscompares = 0;
    int model_last = 1;

    // Observations of one transaction, filled in by run_txn.
    int            obs_win, obs_req_cycles, obs_cyc, obs_owner, obs_viol;
    bit            obs_done, obs_req0, obs_we, obs_err;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_rdata;

    // Arbitration rule: contention goes to whoever was not granted last
    // (or always to r1 in data-priority builds); a lone requester always wins.
    function automatic int model_pick(input bit v0, input bit v1, input int last);
`ifdef ARB_DATA_PRIO_EN
        return v1 ? 1 : 0;
`else
        if (v0 && v1) return 1 - last;
        return v1 ? 1 : 0;
`endif
    endfunction

    // Drives one transaction from IDLE; entered and left at posedge+2.
    // g/r: cycle index after acceptance of mem_gnt/mem_rvalid (-1 = never).
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input bit we0, input bit we1, input int g, input int r,
                           input logic [DW-1:0] rd, input bit noise, input bit keep);
        r0_valid = v0; r1_valid = v1;
        r0_addr = a0; r1_addr = a1; r0_wdata = d0; r1_wdata = d1; r0_we = we0; r1_we = we1;
        @(negedge clk);
        if (r0_ready && r1_ready) obs_win = 2;
        else if (r0_ready) obs_win = 0;
        else if (r1_ready) obs_win = 1;
        else obs_win = -1;
        @(posedge clk); #2;
        if (!keep) begin r0_valid = 1'b0; r1_valid = 1'b0; end
        obs_done = 1'b0; obs_req_cycles = 0; obs_viol = 0; obs_cyc = -1;
        obs_owner = -1; obs_rdata = '0; obs_err = 1'b0;
        for (int c = 0; c < TO + 20 && !obs_done; c++) begin
            mem_gnt    = (c == g);
            mem_rvalid = (c == r) || (noise && c <= g);
            mem_rdata  = (c == r) ? rd : DW'($urandom);
            @(negedge clk);
            if (mem_req) obs_req_cycles++;
            if (c == 0) begin
                obs_req0 = mem_req; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
            end
            if (r0_ready || r1_ready) obs_viol++;
            if (!r0_rvalid && (r0_rdata !== '0 || r0_err)) obs_viol++;
            if (!r1_rvalid && (r1_rdata !== '0 || r1_err)) obs_viol++;
            if (r0_rvalid && r1_rvalid) obs_viol++;
            if (r0_rvalid || r1_rvalid) begin
                obs_done  = 1'b1;
                obs_cyc   = c;
                obs_owner = r1_rvalid ? 1 : 0;
                obs_rdata = r1_rvalid ? r1_rdata : r0_rdata;
                obs_err   = r1_rvalid ? r1_err : r0_err;
            end
            @(posedge clk); #2;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        r0_valid = 1'b1; r1_valid = 1'b1; r0_addr = 32'h1234; r1_addr = 32'h5678;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_err, r1_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b, expected 000000",
                     {r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_err, r1_err});
        end
        vectors++;
        if ({mem_req, mem_we} !== 2'b0) begin
            miscompares++;
            $display("FAIL reset_mem_ctl: got %b, expected 00", {mem_req, mem_we});
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mem_fields: got addr %0h wdata %0h, expected 0 0", mem_addr, mem_wdata);
        end
        vectors++;
        if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %0h %0h, expected 0 0", r0_rdata, r1_rdata);
        end
        r0_valid = 1'b0; r1_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        rst_n = 1'b1;
        model_last = 1;
        @(posedge clk); #2;
        $display("txn reset: released");
    endtask

    task automatic test_read_basic();
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        model_last = 0;
        $display("txn read_basic: win=%0d owner=%0d rdata=%0h err=%0d", obs_win, obs_owner, obs_rdata, obs_err);
        vectors++;
        if (obs_win !== 0) begin
            miscompares++; $display("FAIL basic_win: got %0d, expected 0", obs_win);
        end
        vectors++;
        if (obs_req0 !== 1'b1 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_mem: got req %0d addr %0h we %0d, expected 1 100 0", obs_req0, obs_addr, obs_we);
        end
        vectors++;
        if (obs_owner !== 0 || obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0 || obs_cyc !== 2) begin
            miscompares++;
            $display("FAIL basic_resp: got owner %0d rdata %0h err %0d cyc %0d, expected 0 deadbeef 0 2",
                     obs_owner, obs_rdata, obs_err, obs_cyc);
        end
        vectors++;
        if (obs_viol !== 0 || obs_req_cycles !== 1) begin
            miscompares++;
            $display("FAIL basic_proto: got viol %0d req_cycles %0d, expected 0 1", obs_viol, obs_req_cycles);
        end
    endtask

    task automatic test_back_to_back();
        int exp_order[4];
`ifdef ARB_DATA_PRIO_EN
        exp_order = '{1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_last = 1;
        @(posedge clk); #2;
        for (int t = 0; t < 4; t++) begin
            logic [DW-1:0] rd;
            rd = DW'($urandom);
            run_txn(1'b1, 1'b1, 32'hA000 + AW'(t), 32'hB000 + AW'(t), 32'h0, 32'h0,
                    1'b0, 1'b0, 0, 1, rd, 1'b0, 1'b1);
            $display("txn b2b %0d: win=%0d owner=%0d cyc=%0d", t, obs_win, obs_owner, obs_cyc);
            vectors++;
            if (obs_win !== exp_order[t] || obs_owner !== exp_order[t]) begin
                miscompares++;
                $display("FAIL b2b_order%0d: got win %0d owner %0d, expected %0d", t, obs_win, obs_owner, exp_order[t]);
            end
            vectors++;
            if (obs_addr !== ((exp_order[t] == 1) ? 32'hB000 + AW'(t) : 32'hA000 + AW'(t))
                || obs_rdata !== rd || obs_cyc !== 1 || obs_viol !== 0) begin
                miscompares++;
                $display("FAIL b2b_txn%0d: got addr %0h rdata %0h cyc %0d viol %0d, expected rdata %0h cyc 1 viol 0",
                         t, obs_addr, obs_rdata, obs_cyc, obs_viol, rd);
            end
            model_last = exp_order[t];
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 32'h55AA_55AA, 1'b0, 1'b1, -1, -1, 32'h0, 1'b0, 1'b0);
        model_last = 1;
        $display("txn timeout: win=%0d req_cycles=%0d owner=%0d err=%0d", obs_win, obs_req_cycles, obs_owner, obs_err);
        vectors++;
        if (obs_win !== 1 || obs_addr !== 32'h200 || obs_wdata !== 32'h55AA_55AA || obs_we !== 1'b1) begin
            miscompares++;
            $display("FAIL to_fields: got win %0d addr %0h wdata %0h we %0d, expected 1 200 55aa55aa 1",
                     obs_win, obs_addr, obs_wdata, obs_we);
        end
        vectors++;
        if (obs_req_cycles !== TO || obs_cyc !== TO) begin
            miscompares++;
            $display("FAIL to_len: got req_cycles %0d cyc %0d, expected %0d %0d", obs_req_cycles, obs_cyc, TO, TO);
        end
        vectors++;
        if (obs_owner !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_viol !== 0) begin
            miscompares++;
            $display("FAIL to_resp: got owner %0d err %0d rdata %0h viol %0d, expected 1 1 0 0",
                     obs_owner, obs_err, obs_rdata, obs_viol);
        end
    endtask

    task automatic test_late_resp();
        int bad = 0;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0000 + DW'(c);
            @(negedge clk);
            if (r0_rvalid || r1_rvalid || mem_req || r0_rdata !== '0 || r1_rdata !== '0) bad++;
            @(posedge clk); #2;
        end
        mem_rvalid = 1'b0; mem_rdata = '0;
        $display("txn late_resp: spurious=%0d", bad);
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL late_resp_ignored: got %0d bad cycles, expected 0", bad);
        end
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 3, 32'h1357_9BDF, 1'b0, 1'b0);
        model_last = 0;
        vectors++;
        if (obs_win !== 0 || obs_rdata !== 32'h1357_9BDF || obs_cyc !== 3 || obs_err !== 1'b0) begin
            miscompares++;
            $display("FAIL late_resp_idle: got win %0d rdata %0h cyc %0d err %0d, expected 0 13579bdf 3 0",
                     obs_win, obs_rdata, obs_cyc, obs_err);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        r0_valid = 1'b1; r0_addr = 32'h300; r0_we = 1'b0;
        @(posedge clk); #2;
        r0_valid = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #2;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        #1;
        vectors++;
        if (r0_rvalid !== 1'b1 || mem_addr !== 32'h300) begin
            miscompares++;
            $display("FAIL mid_resp_live: got rvalid %0d addr %0h, expected 1 300", r0_rvalid, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({r0_rvalid, r1_rvalid, r0_err, r1_err, mem_req} !== 5'b0 || r0_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_async_clear: got ctl %b rdata %0h addr %0h, expected 00000 0 0",
                     {r0_rvalid, r1_rvalid, r0_err, r1_err, mem_req}, r0_rdata, mem_addr);
        end
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        model_last = 1;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = (c != 1);
            @(negedge clk);
            if (r0_rvalid || r1_rvalid || r0_ready || r1_ready || mem_req) bad++;
            @(posedge clk); #2;
        end
        mem_rvalid = 1'b0; mem_rdata = '0;
        $display("txn reset_mid: spurious=%0d", bad);
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL mid_no_completion: got %0d bad cycles, expected 0", bad);
        end
        run_txn(1'b1, 1'b1, 32'h10, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1, 32'h2468, 1'b0, 1'b0);
        vectors++;
        if (obs_win !== model_pick(1'b1, 1'b1, 1)) begin
            miscompares++;
            $display("FAIL mid_last_grant: got %0d, expected %0d", obs_win, model_pick(1'b1, 1'b1, 1));
        end
        model_last = model_pick(1'b1, 1'b1, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit v0, v1, we0, we1, noise, exp_ok;
            int g, r, ew, exp_cyc, exp_req;
            logic [AW-1:0] a0, a1;
            logic [DW-1:0] d0, d1, rd, exp_rdata;
            int sel;
            sel = $urandom_range(1, 3);
            v0 = sel[0]; v1 = sel[1];
            a0 = AW'($urandom); a1 = AW'($urandom);
            d0 = DW'($urandom); d1 = DW'($urandom);
            we0 = 1'($urandom); we1 = 1'($urandom);
            rd = DW'($urandom) | 32'h1;
            noise = 1'($urandom);
            g = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) r = -1;
            else if (g < 0) r = $urandom_range(0, 3);
            else r = g + $urandom_range(1, 5);
            ew = model_pick(v0, v1, model_last);
            exp_ok    = (g >= 0) && (g < TO) && (r > g) && (r < TO);
            exp_cyc   = exp_ok ? r : TO;
            exp_req   = (g >= 0 && g < TO) ? g + 1 : TO;
            exp_rdata = exp_ok ? rd : '0;
            run_txn(v0, v1, a0, a1, d0, d1, we0, we1, g, r, rd, noise, 1'b0);
            model_last = ew;
            $display("txn rnd %0d: v=%0d%0d g=%0d r=%0d win=%0d owner=%0d cyc=%0d err=%0d",
                     t, v1, v0, g, r, obs_win, obs_owner, obs_cyc, obs_err);
            vectors++;
            if (obs_win !== ew || obs_owner !== ew) begin
                miscompares++;
                $display("FAIL rnd_win%0d: got win %0d owner %0d, expected %0d", t, obs_win, obs_owner, ew);
            end
            vectors++;
            if (obs_addr !== (ew == 1 ? a1 : a0) || obs_wdata !== (ew == 1 ? d1 : d0)
                || obs_we !== (ew == 1 ? we1 : we0) || obs_req0 !== 1'b1) begin
                miscompares++;
                $display("FAIL rnd_fields%0d: got addr %0h wdata %0h we %0d req %0d, expected %0h %0h %0d 1",
                         t, obs_addr, obs_wdata, obs_we, obs_req0, (ew == 1 ? a1 : a0),
                         (ew == 1 ? d1 : d0), (ew == 1 ? we1 : we0));
            end
            vectors++;
            if (obs_cyc !== exp_cyc || obs_req_cycles !== exp_req || obs_rdata !== exp_rdata
                || obs_err !== !exp_ok || obs_viol !== 0) begin
                miscompares++;
                $display("FAIL rnd_resp%0d: got cyc %0d req %0d rdata %0h err %0d viol %0d, expected %0d %0d %0h %0d 0",
                         t, obs_cyc, obs_req_cycles, obs_rdata, obs_err, obs_viol,
                         exp_cyc, exp_req, exp_rdata, !exp_ok);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_timeout();
        test_late_resp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
